mem_sram_ctrl: RTL and testbench

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

---
 rtl/mem_sram_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_sram_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM.
// Each word is moved as two halfword phases (low, then high).
module mem_sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] LAST_PHASE = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic        is_wr_q, is_wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        we_n_q, we_n_d;

  logic        req;
  logic        last_phase;
  logic [31:0] rel_addr;
  logic        unused_addr_bits;

  // The data segment starts at byte 1024; the SRAM sees word offsets from there.
  assign req              = mem_read | mem_write;
  assign rel_addr         = address - 32'd1024;
  assign unused_addr_bits = ^{rel_addr[31:19], rel_addr[1:0]};
  assign last_phase       = (phase_q == LAST_PHASE);
  assign ready            = (state_q == DONE) || ((state_q == IDLE) && !req);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          phase_d = 3'd0;
          is_wr_d = mem_write;
          word_d  = rel_addr[18:2];
          wdata_d = write_data;
        end
      end
      LOW: begin
        if (last_phase) begin
          state_d = HIGH;
          phase_d = 3'd0;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      HIGH: begin
        if (last_phase) begin
          state_d = DONE;
          phase_d = 3'd0;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so they change cleanly with it.
  always_comb begin
    sram_addr_d = '0;
    dq_out_d    = '0;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    if ((state_d == LOW) || (state_d == HIGH)) begin
      sram_addr_d = {word_d, (state_d == HIGH)};
      if (is_wr_d) begin
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
        dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign read_data   = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (WAIT_CYCLES=1 and 0), an SRAM emulator
// per instance and a per-cycle timeline model of each access.
module tb_mem_sram_ctrl;

  localparam int NI    = 2;
  localparam int MEMSZ = 262144;

  logic clk = 1'b0;
  logic rst;

  logic        mr    [NI];
  logic        mw    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        rdy   [NI];
  logic [17:0] saddr [NI];
  logic [15:0] sdo   [NI];
  logic [15:0] sdi   [NI];
  logic        soe   [NI];
  logic        swe   [NI];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: pos = -1 idle, 1..N low half, N+1..2N high half, 2N+1 done cycle.
  int          pos [NI] = '{-1, -1};
  logic        m_wr [NI];
  logic [16:0] m_wa [NI];
  logic [31:0] m_wd [NI];
  logic [31:0] m_rd [NI];
  logic [15:0] model_mem [NI][MEMSZ];
  logic [15:0] sram_mem  [NI][MEMSZ];
  bit          mem_ready = 1'b0;

  logic [31:0] e_rdy   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
  logic [31:0] e_saddr [6] = '{32'd0, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0};
  logic [31:0] e_do    [6] = '{32'h0, 32'hBEEF, 32'hBEEF, 32'hDEAD, 32'hDEAD, 32'h0};
  logic [31:0] e_we    [6] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
  logic [31:0] r_rdy [6];
  logic [31:0] r_saddr [6];
  logic [31:0] r_do [6];
  logic [31:0] r_we [6];

  always #5 clk = ~clk;

  mem_sram_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .mem_read(mr[0]), .mem_write(mw[0]), .address(addr[0]),
    .write_data(wdata[0]), .read_data(rdata[0]), .ready(rdy[0]), .sram_addr(saddr[0]),
    .sram_dq_out(sdo[0]), .sram_dq_oe(soe[0]), .sram_dq_in(sdi[0]), .sram_we_n(swe[0])
  );

  mem_sram_ctrl #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .mem_read(mr[1]), .mem_write(mw[1]), .address(addr[1]),
    .write_data(wdata[1]), .read_data(rdata[1]), .ready(rdy[1]), .sram_addr(saddr[1]),
    .sram_dq_out(sdo[1]), .sram_dq_oe(soe[1]), .sram_dq_in(sdi[1]), .sram_we_n(swe[1])
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance model and SRAM emulator.
  always @(negedge clk) begin
    int n;
    bit lo, hi, wact;
    logic [31:0] off;
    logic [17:0] ha;
    if (!mem_ready) begin
      for (int k = 0; k < NI; k++)
        for (int a = 0; a < MEMSZ; a++) begin
          model_mem[k][a] = 16'(a * 37 + 5);
          sram_mem[k][a]  = 16'(a * 37 + 5);
        end
      mem_ready = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      n    = (i == 0) ? 2 : 1;
      lo   = (pos[i] >= 1) && (pos[i] <= n);
      hi   = (pos[i] > n) && (pos[i] <= 2 * n);
      wact = (lo || hi) && m_wr[i];
      ha   = {m_wa[i], hi};
      if (chk_en) begin
        chk("ready", i, 32'(rdy[i]), 32'((pos[i] == 2 * n + 1) || (pos[i] < 0 && !(mr[i] || mw[i]))));
        chk("sram_addr", i, 32'(saddr[i]), (lo || hi) ? 32'(ha) : 32'd0);
        chk("sram_we_n", i, 32'(swe[i]), 32'(!wact));
        chk("sram_dq_oe", i, 32'(soe[i]), 32'(wact));
        chk("sram_dq_out", i, 32'(sdo[i]),
            wact ? (hi ? 32'(m_wd[i][31:16]) : 32'(m_wd[i][15:0])) : 32'd0);
        chk("read_data", i, rdata[i], m_rd[i]);
      end
      if (wact) model_mem[i][ha] = hi ? m_wd[i][31:16] : m_wd[i][15:0];
      if (rst) begin
        pos[i]  = -1;
        m_rd[i] = '0;
      end else if (pos[i] < 0) begin
        if (mr[i] || mw[i]) begin
          off     = addr[i] - 32'd1024;
          pos[i]  = 1;
          m_wr[i] = mw[i];
          m_wa[i] = 17'((off / 4) % 131072);
          m_wd[i] = wdata[i];
        end
      end else if (pos[i] <= 2 * n) begin
        if (!m_wr[i] && pos[i] == n) m_rd[i][15:0] = model_mem[i][ha];
        if (!m_wr[i] && pos[i] == 2 * n) m_rd[i][31:16] = model_mem[i][ha];
        pos[i]++;
      end else begin
        pos[i] = -1;
      end
      if (swe[i] === 1'b0) sram_mem[i][saddr[i]] = sdo[i];
      sdi[i] = sram_mem[i][saddr[i]];
    end
  end

  task automatic idle_cycles(input int i, input int n);
    @(posedge clk);
    #1;
    mr[i] = 1'b0;
    mw[i] = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // One pipeline access: holds the request until ready, optionally scrambling inputs mid-access.
  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit scr, output int nc, output logic [31:0] rv);
    bit got;
    @(posedge clk);
    #1;
    mr[i] = r; mw[i] = w; addr[i] = a; wdata[i] = d;
    nc = 0; got = 1'b0; rv = '0;
    while (!got && nc < 40) begin
      @(negedge clk);
      nc++;
      if (rdy[i] === 1'b1) begin
        got = 1'b1;
        rv  = rdata[i];
      end else if (scr) begin
        @(posedge clk);
        #1;
        addr[i] = $urandom;
        wdata[i] = $urandom;
        {mr[i], mw[i]} = 2'($urandom_range(1, 3));
      end
    end
    chk("access_done", i, 32'(got), 32'd1);
  endtask

  task automatic rand_run(input int i, input int n);
    int op, nc;
    logic [31:0] a, rv;
    for (int t = 0; t < n; t++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'd1024 + 32'($urandom_range(0, 255));
      access(i, op != 1, op != 0, a, $urandom, 1'($urandom_range(0, 1)), nc, rv);
      if ($urandom_range(0, 2) != 0) idle_cycles(i, $urandom_range(1, 3));
    end
  endtask

  initial begin
    int nc;
    logic [31:0] rv;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_ready", i, 32'(rdy[i]), 32'd1);
      chk("rst_read_data", i, rdata[i], 32'd0);
      chk("rst_we_n", i, 32'(swe[i]), 32'd1);
      chk("rst_sram_addr", i, 32'(saddr[i]), 32'd0);
    end

    // Write 0xDEADBEEF to 1028, recording the pin sequence cycle by cycle.
    @(posedge clk);
    #1;
    mw[0] = 1'b1; addr[0] = 32'd1028; wdata[0] = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      r_rdy[c] = 32'(rdy[0]); r_saddr[c] = 32'(saddr[0]);
      r_do[c] = 32'(sdo[0]); r_we[c] = 32'(swe[0]);
    end
    idle_cycles(0, 2);
    for (int c = 0; c < 6; c++) begin
      chk("w1028_ready", c, r_rdy[c], e_rdy[c]);
      chk("w1028_sram_addr", c, r_saddr[c], e_saddr[c]);
      chk("w1028_dq_out", c, r_do[c], e_do[c]);
      chk("w1028_we_n", c, r_we[c], e_we[c]);
    end

    access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, nc, rv);
    chk("rd1028_data", 0, rv, 32'hDEADBEEF);
    chk("rd1028_cycles", 0, 32'(nc), 32'd6);
    idle_cycles(0, 3);
    @(negedge clk);
    chk("hold_idle", 0, rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'd2000, 32'h0BADF00D, 1'b0, nc, rv);
    idle_cycles(0, 1);
    @(negedge clk);
    chk("hold_after_write", 0, rdata[0], 32'hDEADBEEF);

    // Back-to-back read then write.
    access(0, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, nc, rv);
    chk("b2b_rd_data", 0, rv, 32'hDEADBEEF);
    chk("b2b_rd_cycles", 0, 32'(nc), 32'd6);
    access(0, 1'b0, 1'b1, 32'd1032, 32'h11112222, 1'b0, nc, rv);
    chk("b2b_wr_cycles", 0, 32'(nc), 32'd6);
    idle_cycles(0, 2);

    // Read and write together is a write.
    access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, nc, rv);
    chk("both_cycles", 0, 32'(nc), 32'd6);
    chk("both_rd_unchanged", 0, rv, 32'hDEADBEEF);
    idle_cycles(0, 1);
    @(negedge clk);
    chk("both_sram_lo", 0, 32'(sram_mem[0][0]), 32'h5678);
    chk("both_sram_hi", 0, 32'(sram_mem[0][1]), 32'h1234);
    access(0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, nc, rv);
    chk("rd1024_data", 0, rv, 32'h12345678);
    idle_cycles(0, 2);

    // Reset on the second high-half cycle of a write.
    @(posedge clk);
    #1;
    mw[0] = 1'b1; addr[0] = 32'd1036; wdata[0] = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; mw[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 0, 32'(rdy[0]), 32'd1);
    chk("rst_mid_we_n", 0, 32'(swe[0]), 32'd1);
    chk("rst_mid_oe", 0, 32'(soe[0]), 32'd0);
    chk("rst_mid_sram_addr", 0, 32'(saddr[0]), 32'd0);
    chk("rst_mid_read_data", 0, rdata[0], 32'd0);

    // Zero wait states.
    access(1, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, nc, rv);
    chk("w0_rd_cycles", 1, 32'(nc), 32'd4);
    chk("w0_rd_data", 1, rv, 32'h002A0005);
    idle_cycles(1, 1);

    fork
      rand_run(0, 150);
      rand_run(1, 150);
    join
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout[0]: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
